vector_exec_unit: RTL and testbench
===================================

VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 Parameter NUM_STREAM_ID, default 5, SHALL set the stream-ID width.
REQ-002 Parameter MIN_VEC_LENGTH, default 16, SHALL set the lane element width.
REQ-003 Parameter NUM_TILES_PER_SLICE, default 20, SHALL set the lane count.
REQ-004 One clock, SHALL be port clk, input, 1: all state updates on its rising edge.
REQ-005 Reset SHALL be port rst, input, 1: synchronous, active-high.
REQ-006 instr_valid, input, 1: instruction offered.
REQ-007 instr_ready, output, 1: instruction accepted when instr_valid && instr_ready at a rising edge.
REQ-008 instr_opcode, input, 3: 0 ADD, 1 SUB, 2 MUL, 3 MAX, 4 MIN, 5 PASS (src1); 6-7 illegal.
REQ-009 instr_src1 / instr_src2 / instr_dest, input, NUM_STREAM_ID each: operand and result stream IDs.
REQ-010 srf_read_enable, output, 1; stream_src1 / stream_src2, output, NUM_STREAM_ID: SRF read request.
REQ-011 srf_data1 / srf_data2, input, MIN_VEC_LENGTH x NUM_TILES_PER_SLICE: SRF read data, valid the cycle after the read-enable cycle.
REQ-012 srf_write_enable, output, 1; stream_dest, output, NUM_STREAM_ID; write_data, output, MIN_VEC_LENGTH x NUM_TILES_PER_SLICE: SRF write request.
REQ-013 done, output, 1: one-cycle pulse on a completed instruction.
REQ-014 illegal_op, output, 1: one-cycle pulse on a rejected opcode.

Function
REQ-015 FSM states SHALL be IDLE, READ, EXEC, WRITE, ERR.
REQ-016 instr_ready SHALL be 1 only in IDLE.
REQ-017 IDLE SHALL go to READ on accept with a legal opcode, to ERR on accept with an illegal opcode, and otherwise stay in IDLE.
REQ-018 On accept, the opcode, src1, src2 and dest SHALL be latched; later changes on the instr_* inputs SHALL have no effect.
REQ-019 READ SHALL last one cycle: srf_read_enable=1 and stream_src1/stream_src2 driven from latched values; next state EXEC.
REQ-020 EXEC SHALL last one cycle: every lane computes op(srf_data1[i], srf_data2[i]) into a result register; next state WRITE.
REQ-021 WRITE SHALL last one cycle: srf_write_enable=1, stream_dest=latched dest, write_data=result register, done=1; next state IDLE.
REQ-022 ERR SHALL last one cycle: illegal_op=1, no SRF read or write; next state IDLE.
REQ-023 Latency SHALL be: accept edge -> READ, EXEC, WRITE in the next three cycles, giving one instruction per 4 cycles maximum.
REQ-024 Arithmetic SHALL be unsigned modulo 2^MIN_VEC_LENGTH: ADD/SUB wrap; MUL keeps the low MIN_VEC_LENGTH bits; MAX/MIN compare unsigned.
REQ-025 All NUM_TILES_PER_SLICE lanes SHALL be computed and written.
REQ-026 src1==src2 and dest==src SHALL be legal; the read precedes the write, so the old value is used.
REQ-027 An instruction accepted after a WRITE SHALL read the data written by that WRITE (no RAW hazard, since IDLE separates them).
REQ-028 Outside their states, srf_read_enable, srf_write_enable, done and illegal_op SHALL be 0, and stream_src1, stream_src2, stream_dest and write_data SHALL hold their last value.

Reset
REQ-029 rst SHALL force IDLE; the result register, stream IDs and write_data SHALL become 0; all enables and pulses SHALL become 0; instr_ready SHALL be 1 in the first cycle after reset.
REQ-030 rst in any state SHALL abort the instruction: no srf_write_enable and no done for it.
REQ-031 rst SHALL take priority over simultaneous instr_valid.

Structure
REQ-032 Shared package tsp_pkg SHALL hold the opcode enum, the FSM state enum and the default values for NUM_STREAM_ID, MIN_VEC_LENGTH and NUM_TILES_PER_SLICE.
REQ-033 Per-lane combinational datapath SHALL be sub-module vector_lane_alu, generated NUM_TILES_PER_SLICE times.
REQ-034 The FSM and all registers SHALL reside in vector_exec_unit.

Verification
REQ-035 ADD, S0 lanes 1..16 (0x0001..0x0010), S4 lanes 0x000A..0x0019, lanes 16-19 zero, dest S8 -> S8[0]=0x000B, S8[15]=0x0029, S8[16..19]=0; srf_write_enable and done exactly 3 cycles after accept.
REQ-036 MUL of 0x0100 x 0x0100 -> 0x0000; SUB of 0x0001 - 0x0002 -> 0xFFFF; MAX(0x8000, 0x7FFF) -> 0x8000.
REQ-037 instr_valid held high for 10 cycles -> accepts only on cycles 0, 4 and 8; instr_ready low in between.
REQ-038 Opcode 7 -> illegal_op pulses 1 cycle after accept; srf_read_enable and srf_write_enable stay 0; instr_ready returns 2 cycles after accept.
REQ-039 rst asserted in EXEC -> no srf_write_enable and no done; the following ADD completes normally.
REQ-040 ADD S0+S4 -> S8, then PASS S8 -> S9 back-to-back -> S9 equals the new S8.

Source files
------------

// File: rtl/tsp_pkg.sv
// Shared definitions for the vector execution unit: default geometry,
// opcode and FSM state encodings, and opcode legality.
package tsp_pkg;

    localparam int DEF_NUM_STREAM_ID       = 5;
    localparam int DEF_MIN_VEC_LENGTH      = 16;
    localparam int DEF_NUM_TILES_PER_SLICE = 20;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_MAX  = 3'd3,
        OP_MIN  = 3'd4,
        OP_PASS = 3'd5
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Encodings 6 and 7 are reserved and must be rejected.
    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_PASS;
    endfunction

endpackage

// File: rtl/vector_lane_alu.sv
// One lane of the vector datapath: purely combinational unsigned
// arithmetic, modulo 2^WIDTH.
module vector_lane_alu
    import tsp_pkg::*;
#(
    parameter int WIDTH = DEF_MIN_VEC_LENGTH
) (
    input  logic [2:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] product;

    // Only the low WIDTH bits of the product are kept.
    assign product = a_i * b_i;

    always_comb begin
        // NOTE: default first so every path assigns result_o and no latch is inferred.
        result_o = a_i;
        case (opcode_e'(opcode_i))
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_MUL:  result_o = product;
            OP_MAX:  result_o = (a_i >= b_i) ? a_i : b_i;
            OP_MIN:  result_o = (a_i <= b_i) ? a_i : b_i;
            OP_PASS: result_o = a_i;
            default: result_o = a_i;
        endcase
    end

endmodule

// File: rtl/vector_exec_unit.sv
// Vector execution unit: accepts one instruction, reads two SRF streams,
// applies the opcode lane-wise and writes the result stream back.
module vector_exec_unit
    import tsp_pkg::*;
#(
    parameter int NUM_STREAM_ID       = DEF_NUM_STREAM_ID,
    parameter int MIN_VEC_LENGTH      = DEF_MIN_VEC_LENGTH,
    parameter int NUM_TILES_PER_SLICE = DEF_NUM_TILES_PER_SLICE
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          instr_valid,
    output logic                                          instr_ready,
    input  logic [2:0]                                    instr_opcode,
    input  logic [NUM_STREAM_ID-1:0]                      instr_src1,
    input  logic [NUM_STREAM_ID-1:0]                      instr_src2,
    input  logic [NUM_STREAM_ID-1:0]                      instr_dest,
    output logic                                          srf_read_enable,
    output logic [NUM_STREAM_ID-1:0]                      stream_src1,
    output logic [NUM_STREAM_ID-1:0]                      stream_src2,
    input  logic [MIN_VEC_LENGTH*NUM_TILES_PER_SLICE-1:0] srf_data1,
    input  logic [MIN_VEC_LENGTH*NUM_TILES_PER_SLICE-1:0] srf_data2,
    output logic                                          srf_write_enable,
    output logic [NUM_STREAM_ID-1:0]                      stream_dest,
    output logic [MIN_VEC_LENGTH*NUM_TILES_PER_SLICE-1:0] write_data,
    output logic                                          done,
    output logic                                          illegal_op
);

    localparam int VEC_W = MIN_VEC_LENGTH * NUM_TILES_PER_SLICE;

    state_e                   state_q, state_d;
    logic [2:0]               opcode_q;
    logic [NUM_STREAM_ID-1:0] src1_q, src2_q, dest_q, wr_dest_q;
    logic [VEC_W-1:0]         result_q;
    logic [VEC_W-1:0]         lane_result;
    logic                     accept;
    logic                     accept_legal;

    assign accept       = instr_valid && instr_ready;
    assign accept_legal = accept && is_legal_op(instr_opcode);

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking (<=); the reset branch is synchronous and only acts on an edge.
        if (rst) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            dest_q    <= '0;
            wr_dest_q <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opcode_q <= instr_opcode;
                dest_q   <= instr_dest;
            end
            // Read IDs only move for a legal instruction, so a rejected opcode
            // leaves stream_src1/stream_src2 at their previous values.
            if (accept_legal) begin
                src1_q <= instr_src1;
                src2_q <= instr_src2;
            end
            if (state_q == ST_EXEC) begin
                result_q  <= lane_result;
                wr_dest_q <= dest_q;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        instr_ready      = 1'b0;
        srf_read_enable  = 1'b0;
        srf_write_enable = 1'b0;
        done             = 1'b0;
        illegal_op       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = is_legal_op(instr_opcode) ? ST_READ : ST_ERR;
                end
            end
            ST_READ: begin
                srf_read_enable = 1'b1;
                state_d         = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                srf_write_enable = 1'b1;
                done             = 1'b1;
                state_d          = ST_IDLE;
            end
            ST_ERR: begin
                illegal_op = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_TILES_PER_SLICE; i++) begin : g_lane
        vector_lane_alu #(
            .WIDTH(MIN_VEC_LENGTH)
        ) u_alu (
            .opcode_i(opcode_q),
            .a_i     (srf_data1[i*MIN_VEC_LENGTH +: MIN_VEC_LENGTH]),
            .b_i     (srf_data2[i*MIN_VEC_LENGTH +: MIN_VEC_LENGTH]),
            .result_o(lane_result[i*MIN_VEC_LENGTH +: MIN_VEC_LENGTH])
        );
    end

    assign stream_src1 = src1_q;
    assign stream_src2 = src2_q;
    assign stream_dest = wr_dest_q;
    assign write_data  = result_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Self-checking bench for vector_exec_unit: a behavioural SRF feeds the DUT,
// and a lane-array reference model predicts every written stream.
module tb_vector_exec_unit;

    localparam int SID = 5;
    localparam int W   = 16;
    localparam int N   = 20;
    localparam int DW  = W * N;
    localparam int NS  = 1 << SID;

    logic           clk = 1'b0;
    logic           rst;
    logic           instr_valid;
    logic           instr_ready;
    logic [2:0]     instr_opcode;
    logic [SID-1:0] instr_src1, instr_src2, instr_dest;
    logic           srf_read_enable;
    logic [SID-1:0] stream_src1, stream_src2;
    logic [DW-1:0]  srf_data1, srf_data2;
    logic           srf_write_enable;
    logic [SID-1:0] stream_dest;
    logic [DW-1:0]  write_data;
    logic           done;
    logic           illegal_op;

    vector_exec_unit #(
        .NUM_STREAM_ID      (SID),
        .MIN_VEC_LENGTH     (W),
        .NUM_TILES_PER_SLICE(N)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_opcode    (instr_opcode),
        .instr_src1      (instr_src1),
        .instr_src2      (instr_src2),
        .instr_dest      (instr_dest),
        .srf_read_enable (srf_read_enable),
        .stream_src1     (stream_src1),
        .stream_src2     (stream_src2),
        .srf_data1       (srf_data1),
        .srf_data2       (srf_data2),
        .srf_write_enable(srf_write_enable),
        .stream_dest     (stream_dest),
        .write_data      (write_data),
        .done            (done),
        .illegal_op      (illegal_op)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: stream contents as plain lane arrays.
    logic [W-1:0]  ref_mem [NS][N];
    // Environment SRF, updated only by DUT writes.
    logic [DW-1:0] srf_mem [NS];

    logic [DW-1:0]  last_wd;
    logic [SID-1:0] last_dest;

    function automatic logic [W-1:0] ref_op(input int op, input int a, input int b);
        longint m = longint'(1) << W;
        longint r;
        case (op)
            0:       r = a + b;
            1:       r = a - b + m;
            2:       r = longint'(a) * longint'(b);
            3:       r = (a > b) ? a : b;
            4:       r = (a < b) ? a : b;
            default: r = a;
        endcase
        r = r % m;
        return r[W-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [DW-1:0] predict(input int op, input int s1, input int s2);
        logic [DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = ref_op(op, ref_mem[s1][i], ref_mem[s2][i]);
        return v;
    endfunction

    task automatic set_lane(input int s, input int lane, input logic [W-1:0] val);
        ref_mem[s][lane]        = val;
        srf_mem[s][lane*W +: W] = val;
    endtask

    // SRF: requests seen during the READ cycle return data in the following cycle only.
    bit             rd_pending = 1'b0;
    logic [SID-1:0] rd_id1, rd_id2;

    always @(negedge clk) begin
        if (srf_write_enable) srf_mem[stream_dest] = write_data;
        rd_pending = srf_read_enable;
        rd_id1     = stream_src1;
        rd_id2     = stream_src2;
    end

    always @(posedge clk) begin
        #1;
        if (rd_pending) begin
            srf_data1 = srf_mem[rd_id1];
            srf_data2 = srf_mem[rd_id2];
        end else begin
            srf_data1 = rand_vec();
            srf_data2 = rand_vec();
        end
        rd_pending = 1'b0;
    end

    // Issue one instruction at the next IDLE cycle and follow it to completion.
    task automatic do_instr(input int op, input int s1, input int s2, input int d,
                            output logic [DW-1:0] wd);
        logic [DW-1:0] exp_v;
        bit            legal;
        legal = (op < 6);
        exp_v = predict(op, s1, s2);
        wd    = last_wd;
        @(negedge clk);
        check("idle_ready", instr_ready, 1);
        check("idle_hold_wdata", write_data, last_wd);
        check("idle_hold_dest", stream_dest, last_dest);
        check("idle_no_pulse", {srf_write_enable, done, illegal_op, srf_read_enable}, 0);
        instr_valid  = 1'b1;
        instr_opcode = 3'(op);
        instr_src1   = SID'(s1);
        instr_src2   = SID'(s2);
        instr_dest   = SID'(d);
        @(posedge clk);
        #1;
        instr_valid  = 1'b0;
        instr_opcode = 3'($urandom);
        instr_src1   = SID'($urandom);
        instr_src2   = SID'($urandom);
        instr_dest   = SID'($urandom);
        @(negedge clk);
        if (legal) begin
            check("read_en", srf_read_enable, 1);
            check("read_src1", stream_src1, s1);
            check("read_src2", stream_src2, s2);
            check("read_busy", {instr_ready, srf_write_enable, done, illegal_op}, 0);
        end else begin
            check("err_pulse", illegal_op, 1);
            check("err_no_srf", {srf_read_enable, srf_write_enable, done, instr_ready}, 0);
            check("err_hold_wdata", write_data, last_wd);
        end
        @(negedge clk);
        if (!legal) begin
            check("err_ready_back", instr_ready, 1);
            check("err_pulse_once", illegal_op, 0);
            return;
        end
        check("exec_quiet", {srf_read_enable, srf_write_enable, done, instr_ready}, 0);
        @(negedge clk);
        check("write_en", srf_write_enable, 1);
        check("write_done", done, 1);
        check("write_dest", stream_dest, d);
        check("write_data", write_data, exp_v);
        wd = write_data;
        for (int i = 0; i < N; i++) ref_mem[d][i] = exp_v[i*W +: W];
        last_wd   = exp_v;
        last_dest = SID'(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [DW-1:0] wd;
        logic [9:0]    mask;
        int            wr_cnt, done_cnt, seen;
        int            op, s1, s2, d;

        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr_opcode = '0;
        instr_src1   = '0;
        instr_src2   = '0;
        instr_dest   = '0;
        srf_data1    = '0;
        srf_data2    = '0;
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < N; i++) set_lane(s, i, W'($urandom));
        for (int i = 0; i < N; i++) begin
            set_lane(0, i, (i < 16) ? W'(i + 1) : '0);
            set_lane(4, i, (i < 16) ? W'(i + 10) : '0);
            set_lane(1, i, 16'h0100);
            set_lane(2, i, 16'h0100);
            set_lane(5, i, 16'h0001);
            set_lane(6, i, 16'h0002);
            set_lane(7, i, 16'h8000);
            set_lane(10, i, 16'h7FFF);
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_pulses", {srf_read_enable, srf_write_enable, done, illegal_op}, 0);
        check("rst_wdata", write_data, 0);
        check("rst_ids", {stream_src1, stream_src2, stream_dest}, 0);
        last_wd   = '0;
        last_dest = '0;

        do_instr(0, 0, 4, 8, wd);
        check("add_lane0", wd[0 +: W], 16'h000B);
        check("add_lane15", wd[15*W +: W], 16'h0029);
        check("add_lane16_19", wd[DW-1 -: 4*W], 0);
        do_instr(5, 8, 8, 9, wd);
        check("pass_new_s8", wd, srf_mem[8]);

        do_instr(2, 1, 2, 3, wd);
        check("mul_wrap", wd[0 +: W], 16'h0000);
        do_instr(1, 5, 6, 11, wd);
        check("sub_wrap", wd[0 +: W], 16'hFFFF);
        do_instr(3, 7, 10, 12, wd);
        check("max_unsigned", wd[0 +: W], 16'h8000);
        do_instr(4, 7, 10, 14, wd);
        check("min_unsigned", wd[0 +: W], 16'h7FFF);

        do_instr(7, 1, 2, 3, wd);
        do_instr(6, 4, 5, 6, wd);

        // Valid held high: accepts only every fourth cycle.
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_opcode = 3'd0;
        instr_src1   = SID'(11);
        instr_src2   = SID'(12);
        instr_dest   = SID'(13);
        mask     = '0;
        wr_cnt   = 0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 10) mask[c] = instr_ready;
            if (c == 9) instr_valid = 1'b0;
            wr_cnt   += int'(srf_write_enable);
            done_cnt += int'(done);
        end
        check("hold_valid_accepts", mask, 10'h111);
        check("hold_valid_writes", wr_cnt, 3);
        check("hold_valid_done", done_cnt, 3);
        last_wd = predict(0, 11, 12);
        check("hold_valid_data", write_data, last_wd);
        for (int i = 0; i < N; i++) ref_mem[13][i] = last_wd[i*W +: W];
        last_dest = SID'(13);

        // Reset during EXEC aborts the instruction.
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_opcode = 3'd0;
        instr_src1   = SID'(0);
        instr_src2   = SID'(4);
        instr_dest   = SID'(15);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("abort_ready", instr_ready, 1);
                check("abort_wdata_cleared", write_data, 0);
            end
            seen += int'(srf_write_enable) + int'(done);
        end
        check("abort_no_write", seen, 0);
        last_wd   = '0;
        last_dest = '0;
        do_instr(0, 0, 4, 15, wd);

        // Reset wins over a simultaneous valid.
        @(negedge clk);
        rst          = 1'b1;
        instr_valid  = 1'b1;
        instr_opcode = 3'd0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        check("rst_prio_ready", instr_ready, 1);
        @(negedge clk);
        check("rst_prio_no_read", srf_read_enable, 0);
        last_wd   = '0;
        last_dest = '0;

        for (int k = 0; k < 40; k++) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            s1 = int'($urandom_range(0, NS - 1));
            s2 = ($urandom_range(0, 3) == 0) ? s1 : int'($urandom_range(0, NS - 1));
            d  = ($urandom_range(0, 3) == 0) ? s2 : int'($urandom_range(0, NS - 1));
            do_instr(op, s1, s2, d, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
